// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit: reset PC, NOP encoding
// and the fetch FSM state encoding.
package instruction_fetch_unit_pkg;

    // Byte address of program ROM word 0; also the PC value after reset.
    localparam logic [31:0] DEFAULT_TEXT_BASE = 32'h00400000;

    // Encoding captured into IF/ID whenever it holds a bubble.
    localparam logic [31:0] NOP_INSTR = 32'h00000000;

    // Fetch FSM states.
    localparam logic [1:0] FETCH_BOOT  = 2'd0;
    localparam logic [1:0] FETCH_RUN   = 2'd1;
    localparam logic [1:0] FETCH_FAULT = 2'd2;

    // Instruction fetches must be word aligned.
    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_ifid_register.sv
// IF/ID pipeline register with three update modes, in priority order:
// bubble (load NOP / zero), hold (keep contents), load (capture new word).
module ifid_register
    import instruction_fetch_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bubble,
    input  logic                  hold,
    input  logic [DATA_WIDTH-1:0] instr_in,
    input  logic [DATA_WIDTH-1:0] pc_plus4_in,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] pc_plus4,
    output logic                  valid
);

    // Bubble wins over hold so that a redirect always squashes a stalled slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr    <= '0;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (bubble) begin
            instr    <= DATA_WIDTH'(NOP_INSTR);
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (!hold) begin
            instr    <= instr_in;
            pc_plus4 <= pc_plus4_in;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, presents it to the combinational
// program ROM, captures the returned word into IF/ID, applies stall, flush
// and branch/jump redirects, and traps fetches that leave the text segment.
//
// Memory interface: PCAddress is the request; Instruction is the
// combinational response for that address in the same cycle. There is no
// valid/ready pair and no wait state: every cycle in RUN is a completed read.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                    MEMORY_DEPTH = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = DATA_WIDTH'(DEFAULT_TEXT_BASE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  BranchTaken,
    input  logic [DATA_WIDTH-1:0] BranchTarget,
    input  logic                  JumpTaken,
    input  logic [DATA_WIDTH-1:0] JumpTarget,
    input  logic [DATA_WIDTH-1:0] Instruction,
    output logic [DATA_WIDTH-1:0] PCAddress,
    output logic [DATA_WIDTH-1:0] IFID_Instruction,
    output logic [DATA_WIDTH-1:0] IFID_PCPlus4,
    output logic                  IFID_Valid,
    output logic                  Fault,
    output logic [DATA_WIDTH-1:0] FaultPC
);

    // One past the last legal byte address, one bit wider so the end of a
    // segment placed at the top of the address space cannot wrap.
    localparam logic [DATA_WIDTH:0] TEXT_END =
        {1'b0, TEXT_BASE} + (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);

    logic [1:0]            state;
    logic [1:0]            next_state;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] candidate_pc;
    logic                  candidate_in_range;
    logic                  candidate_bad;
    logic                  in_run;
    logic                  redirect;
    logic                  fault_entry;
    logic                  ifid_bubble;
    logic                  ifid_hold;

    assign in_run   = (state == FETCH_RUN);
    assign redirect = BranchTaken | JumpTaken;

    // Sequential successor wraps mod 2^DATA_WIDTH; a wrapped value is
    // outside the text segment and is caught by the range check below.
    assign pc_plus4 = PCAddress + DATA_WIDTH'(4);

    // Next-PC selection: the branch is older than the jump, so it wins;
    // either redirect overrides a stall.
    always_comb begin
        candidate_pc = pc_plus4;
        if (BranchTaken) begin
            candidate_pc = BranchTarget;
        end else if (JumpTaken) begin
            candidate_pc = JumpTarget;
        end else if (Stall) begin
            candidate_pc = PCAddress;
        end
    end

    // Range / alignment check on the PC that would be fetched next.
    always_comb begin
        candidate_in_range = ({1'b0, candidate_pc} >= {1'b0, TEXT_BASE}) &&
                             ({1'b0, candidate_pc} <  TEXT_END);
        candidate_bad      = !is_word_aligned(candidate_pc[1:0]) || !candidate_in_range;
    end

    assign fault_entry = in_run && candidate_bad;

    // Fetch FSM: BOOT lasts one cycle, RUN fetches, FAULT is left only by reset.
    always_comb begin
        next_state = state;
        case (state)
            FETCH_BOOT:  next_state = FETCH_RUN;
            FETCH_RUN:   next_state = candidate_bad ? FETCH_FAULT : FETCH_RUN;
            FETCH_FAULT: next_state = FETCH_FAULT;
            default:     next_state = FETCH_BOOT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH_BOOT;
        end else begin
            state <= next_state;
        end
    end

    // PC register: advances only in RUN and only to a legal address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PCAddress <= TEXT_BASE;
        end else if (in_run && !candidate_bad) begin
            PCAddress <= candidate_pc;
        end
    end

    // Sticky fault flag and the offending next-PC, captured once on entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Fault   <= 1'b0;
            FaultPC <= '0;
        end else if (fault_entry) begin
            Fault   <= 1'b1;
            FaultPC <= candidate_pc;
        end
    end

    // IF/ID control. The word at the current PC is legal even when its
    // successor is not, so on the fault-entry edge IF/ID follows the normal
    // RUN rules (a sequential fall-off still captures the last word). Once
    // in FAULT, and during BOOT, IF/ID is loaded with bubbles.
    always_comb begin
        ifid_bubble = 1'b1;
        ifid_hold   = 1'b0;
        if (in_run) begin
            ifid_bubble = redirect | Flush;
            ifid_hold   = Stall;
        end
    end

    ifid_register #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ifid (
        .clk         (clk),
        .reset       (reset),
        .bubble      (ifid_bubble),
        .hold        (ifid_hold),
        .instr_in    (Instruction),
        .pc_plus4_in (pc_plus4),
        .instr       (IFID_Instruction),
        .pc_plus4    (IFID_PCPlus4),
        .valid       (IFID_Valid)
    );

endmodule
